// File: rtl/debug_pkg.sv
// Shared constants and types for the pipeline debug controller.
// Command bytes arrive from the UART receiver.
package debug_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
    localparam logic [7:0] CMD_CLEAR = 8'h72;  // 'r'

    localparam int DUMP_WORDS_DEFAULT = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_CLEAR,
        ST_DUMP
    } ctrlState_t;

endpackage

// File: rtl/debug_unit_dump_serializer.sv
// Streams DUMP_WORDS readout words plus the cycle count to the UART, MSB first.
// Runs one full dump per start pulse and pulses done as the last byte completes.
module dump_serializer
    import debug_pkg::*;
#(
    parameter int DUMP_WORDS = DUMP_WORDS_DEFAULT,
    parameter int ADDR_W     = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    input  logic              txBusy,
    output logic              txStart,
    output logic [7:0]        txData,
    output logic [ADDR_W-1:0] dumpAddr,
    input  logic [31:0]       dumpData,
    input  logic [31:0]       cycleCount
);

    localparam logic [2:0] SER_IDLE    = 3'd0;
    localparam logic [2:0] SER_LOAD    = 3'd1;
    localparam logic [2:0] SER_SEND    = 3'd2;
    localparam logic [2:0] SER_WAIT_HI = 3'd3;
    localparam logic [2:0] SER_WAIT_LO = 3'd4;

    // One extra index value selects the cycle-count word after the readout words.
    localparam int IDX_W = $clog2(DUMP_WORDS + 1);
    localparam logic [IDX_W-1:0] COUNT_WORD = IDX_W'(DUMP_WORDS);

    logic [2:0]       state;
    logic [IDX_W-1:0] wordIdx;
    logic [1:0]       byteIdx;
    logic [31:0]      shiftReg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset branch clears all of them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= SER_IDLE;
            wordIdx  <= '0;
            byteIdx  <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                SER_IDLE: begin
                    if (start) begin
                        state   <= SER_LOAD;
                        wordIdx <= '0;
                        byteIdx <= '0;
                    end
                end
                SER_LOAD: begin
                    shiftReg <= (wordIdx == COUNT_WORD) ? cycleCount : dumpData;
                    byteIdx  <= '0;
                    state    <= SER_SEND;
                end
                SER_SEND: begin
                    if (!txBusy) state <= SER_WAIT_HI;
                end
                SER_WAIT_HI: begin
                    if (txBusy) state <= SER_WAIT_LO;
                end
                SER_WAIT_LO: begin
                    if (!txBusy) begin
                        shiftReg <= shiftReg << 8;
                        if (byteIdx != 2'd3) begin
                            byteIdx <= byteIdx + 2'd1;
                            state   <= SER_SEND;
                        end else if (wordIdx != COUNT_WORD) begin
                            wordIdx <= wordIdx + IDX_W'(1);
                            state   <= SER_LOAD;
                        end else begin
                            wordIdx <= '0;
                            byteIdx <= '0;
                            state   <= SER_IDLE;
                        end
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

    assign txData  = shiftReg[31:24];
    assign txStart = (state == SER_SEND) && !txBusy;
    assign done    = (state == SER_WAIT_LO) && !txBusy && (byteIdx == 2'd3)
                     && (wordIdx == COUNT_WORD);

    // The readout mux has no entry for the count word, so hold the last real address.
    assign dumpAddr = (wordIdx == COUNT_WORD) ? ADDR_W'(DUMP_WORDS - 1) : ADDR_W'(wordIdx);

endmodule

// File: rtl/debug_unit.sv
// Host-side run/step/clear controller for the pipeline-latch debug interface.
// Counts enabled cycles and hands halted-state dumps to the serializer.
module debug_unit
    import debug_pkg::*;
#(
    parameter int DUMP_WORDS = DUMP_WORDS_DEFAULT,
    parameter int ADDR_W     = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rxData,
    input  logic              rxValid,
    output logic [7:0]        txData,
    output logic              txStart,
    input  logic              txBusy,
    input  logic              eop,
    output logic [ADDR_W-1:0] dumpAddr,
    input  logic [31:0]       dumpData,
    output logic              debugEnable,
    output logic              debugReset
);

    ctrlState_t  state;
    logic [31:0] cycleCount;
    logic        dumpStart;
    logic        dumpDone;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cycleCount <= '0;
        end else begin
            if (state == ST_CLEAR)
                cycleCount <= '0;
            else if (debugEnable)
                cycleCount <= cycleCount + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (rxValid) begin
                        if (rxData == CMD_RUN)        state <= ST_RUN;
                        else if (rxData == CMD_STEP)  state <= ST_STEP;
                        else if (rxData == CMD_CLEAR) state <= ST_CLEAR;
                    end
                end
                // A halt wins over a clear arriving in the same cycle.
                ST_RUN: begin
                    if (eop)                                state <= ST_DUMP;
                    else if (rxValid && rxData == CMD_CLEAR) state <= ST_CLEAR;
                end
                ST_STEP:  state <= ST_DUMP;
                ST_CLEAR: state <= ST_IDLE;
                ST_DUMP: begin
                    if (dumpDone) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign debugEnable = (state == ST_RUN) || (state == ST_STEP);
    assign debugReset  = (state == ST_CLEAR);
    assign dumpStart   = (state == ST_STEP) || ((state == ST_RUN) && eop);

    dump_serializer #(
        .DUMP_WORDS (DUMP_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_serializer (
        .clock      (clock),
        .reset      (reset),
        .start      (dumpStart),
        .done       (dumpDone),
        .txBusy     (txBusy),
        .txStart    (txStart),
        .txData     (txData),
        .dumpAddr   (dumpAddr),
        .dumpData   (dumpData),
        .cycleCount (cycleCount)
    );

endmodule
